frame_rom_arbiter: RTL and testbench

//  Shares one synchronous, palette-indexed sprite/background ROM read port among NUM_REQ requesters.

---
 rtl/frame_rom_arbiter.sv | 120 ++++++++++++
 tb/tb_frame_rom_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/frame_rom_arbiter.sv
// Arbiter that shares one synchronous sprite/background ROM read port among NUM_REQ requesters.
// It steers each returned palette index back to the requester that issued the read.
module frame_rom_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 4,
  parameter int ROM_LAT    = 1,
  parameter int PRI0_EN    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_rd,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [7:0] STARVE_TH = 8'(STARVE_MAX);

  logic [IDX_W-1:0]   ptr;
  logic [7:0]         starve_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] starved;
  logic               win_any;
  logic               win_pri;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [ADDR_W-1:0]  win_addr;
  logic [ROM_LAT-1:0] pipe_vld;
  logic [IDX_W-1:0]   pipe_id [ROM_LAT];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = req[i] && (starve_cnt[i] >= STARVE_TH);
    end
  end

  // Starvation override, then fixed priority for req 0, then round-robin from ptr.
  always_comb begin
    win_any = 1'b0;
    win_pri = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_any && starved[i]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    if (!win_any && (PRI0_EN != 0) && req[0]) begin
      win_any = 1'b1;
      win_pri = 1'b1;
      win_idx = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_any && req[i] && (IDX_W'(i) >= ptr)) begin
        win_any = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_any && req[i]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = win_any && (win_idx == IDX_W'(i));
      if (win_idx == IDX_W'(i)) win_addr = addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign gnt = Reset_n ? win_oh : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr      <= '0;
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      pipe_vld <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
      for (int s = 0; s < ROM_LAT; s++) pipe_id[s] <= '0;
    end else begin
      if (win_any && !win_pri) begin
        ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !gnt[i]) begin
          starve_cnt[i] <= (starve_cnt[i] == 8'hFF) ? 8'hFF : starve_cnt[i] + 8'd1;
        end else begin
          starve_cnt[i] <= '0;
        end
      end
      rom_rd <= win_any;
      if (win_any) rom_addr <= win_addr;
      // Last ID stage lines up with rom_data, ROM_LAT edges after the issue edge.
      pipe_vld[0] <= win_any;
      pipe_id[0]  <= win_idx;
      for (int s = 1; s < ROM_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_valid[i] <= pipe_vld[ROM_LAT-1] && (pipe_id[ROM_LAT-1] == IDX_W'(i));
      end
      if (pipe_vld[ROM_LAT-1]) rd_data <= rom_data;
    end
  end

endmodule

// File: tb/tb_frame_rom_arbiter.sv
// Directed bench for frame_rom_arbiter (3 requesters, ROM_LAT=2, req 0 priority, STARVE_MAX=8).
// A one-register ROM model returns addr[3:0]+4'hA, sampled two edges after the issue edge.
module tb_frame_rom_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 4;

  logic                      Clk;
  logic                      Reset_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rom_rd;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [DATA_W-1:0]         rom_q;

  int vectors = 0;
  int miscompares = 0;

  frame_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ROM_LAT(2), .PRI0_EN(1), .STARVE_MAX(8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .addr(addr), .gnt(gnt),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_q <= rom_addr[3:0] + 4'hA;
  assign rom_data = rom_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int idx, input logic [ADDR_W-1:0] a);
    addr[idx*ADDR_W +: ADDR_W] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    req     = 3'b111;
    addr    = '0;
    set_addr(0, 17'h01F00);
    set_addr(1, 17'h01F11);
    set_addr(2, 17'h01F22);

    // T1: reset holds everything quiet, req 0 wins on release
    @(negedge Clk); #1;
    chk("t1_rst_gnt", 32'(gnt), 32'h0);
    chk("t1_rst_rom_rd", 32'(rom_rd), 32'h0);
    chk("t1_rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("t1_rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("t1_rst_rd_data", 32'(rd_data), 32'h0);
    @(negedge Clk); Reset_n = 1'b1; #1;
    chk("t1_first_gnt", 32'(gnt), 32'h1);
    @(negedge Clk); req = 3'b000; #1;
    chk("t1_rom_rd", 32'(rom_rd), 32'h1);
    chk("t1_rom_addr", 32'(rom_addr), 32'h01F00);
    chk("t1_idle_gnt", 32'(gnt), 32'h0);
    repeat (4) @(negedge Clk);

    // T2: round-robin between req 1 and req 2
    set_addr(1, 17'h00111);
    set_addr(2, 17'h00222);
    for (int k = 0; k < 7; k++) begin
      @(negedge Clk);
      req = (k < 6) ? 3'b110 : 3'b000;
      #1;
      if (k < 6) chk("t2_gnt", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h4);
      if (k >= 1) chk("t2_rom_addr", 32'(rom_addr), ((k - 1) % 2 == 0) ? 32'h00111 : 32'h00222);
    end
    repeat (4) @(negedge Clk);

    // T3: latency of a single read
    @(negedge Clk); req = 3'b010; set_addr(1, 17'h0ABCD); #1;
    chk("t3_gnt", 32'(gnt), 32'h2);
    for (int d = 1; d <= 3; d++) begin
      @(negedge Clk); req = 3'b000; #1;
      if (d == 1) chk("t3_rom_addr", 32'(rom_addr), 32'h0ABCD);
      chk("t3_rd_valid", 32'(rd_valid), (d == 3) ? 32'h2 : 32'h0);
      if (d == 3) chk("t3_rd_data", 32'(rd_data), 32'h7);
    end
    repeat (2) @(negedge Clk);

    // T4: req 2 forced through after 8 lost cycles
    set_addr(0, 17'h00AAA);
    set_addr(2, 17'h00CCC);
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk); req = 3'b101; #1;
      chk("t4_gnt", 32'(gnt), (k == 9) ? 32'h4 : 32'h1);
    end
    @(negedge Clk); req = 3'b000;
    repeat (4) @(negedge Clk);

    // T5: back-to-back reads from req 2, returns in order with no gaps
    for (int k = 1; k <= 9; k++) begin
      @(negedge Clk);
      if (k <= 5) begin
        req = 3'b100;
        set_addr(2, 17'(k - 1));
      end else begin
        req = 3'b000;
      end
      #1;
      chk("t5_gnt", 32'(gnt), (k <= 5) ? 32'h4 : 32'h0);
      chk("t5_rd_valid", 32'(rd_valid), (k >= 4 && k <= 8) ? 32'h4 : 32'h0);
      if (k >= 4 && k <= 8) chk("t5_rd_data", 32'(rd_data), 32'hA + 32'(k - 4));
    end

    // T6: reset while three reads are in flight discards every return
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk); req = 3'b001; set_addr(0, 17'(k)); #1;
      chk("t6_gnt", 32'(gnt), 32'h1);
    end
    @(posedge Clk); #1; Reset_n = 1'b0; #1;
    chk("t6_rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    @(negedge Clk); req = 3'b000;
    @(negedge Clk); Reset_n = 1'b1; #1;
    chk("t6_rel_rom_rd", 32'(rom_rd), 32'h0);
    chk("t6_rel_rd_data", 32'(rd_data), 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk); #1;
      chk("t6_no_return", 32'(rd_valid), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
